float16_accumulator: RTL
========================

# float16_accumulator

Sequential FP16 multiply-accumulate back end for the fully-connected layers: consumes a stream of NUM_TERMS FP16 products per neuron over a valid/ready handshake, adds them one at a time into a bias-initialised accumulator, and presents the finished sum on a valid/ready output. It sits downstream of the product generator and upstream of activation/output storage. Its internal adder implements the team's FP16 add semantics as a two-stage registered datapath.

## Interface
- NUM_TERMS, 120, products accumulated per neuron (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; honoured only in IDLE; latches bias.
- bias  input  16  FP16 initial accumulator value, sampled with start.
- in_valid  input  1  in_data valid.
- in_ready  output  1  accumulator can accept a term.
- in_data  input  16  FP16 term.
- out_valid  output  1  out_data holds the final sum.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  16  FP16 accumulated result.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT, ALIGN, NORM, DONE.
- IDLE: in_ready=0. On start: acc<=bias, cnt<=0, go WAIT.
- WAIT: in_ready=1. On in_valid&&in_ready: register in_data as x, go ALIGN.
- ALIGN: register special-case flags, larger exponent, aligned 11-bit fractions, signs.
- NORM: compute add/normalise, acc<=result, cnt<=cnt+1; if cnt==NUM_TERMS-1 go DONE, else WAIT.
- DONE: out_valid=1, out_data=acc; on out_ready go IDLE.
- start outside IDLE, and in_valid outside WAIT, are ignored.
- Add semantics, result = add(acc, x):
  - x==0x0000 -> acc; else acc==0x0000 -> x; else bits[14:0] equal and signs differ -> 0x0000. 0x8000 is not treated as zero.
  - Implicit leading 1 always prepended (no subnormal handling). Smaller-exponent fraction shifted right by the exponent difference, truncating. Shifts ≥11 give 0. Result exponent is the larger one.
  - Same sign: 12-bit sum; on carry shift right 1, exponent+1; sign is the common sign.
  - Different sign: positive minus negative fraction, 12-bit; borrow -> sign=1, fraction negated; else sign=0.
  - Normalise: if bit10 is clear, left-shift to the leading one (1..10 places) and subtract the same from the exponent.
  - Exponent is held 6-bit signed. If bit5 is set (underflow below 0, or overflow to 32) -> 0x0000; else {sign, exp[4:0], frac[9:0]}. No rounding.
- cnt width is $clog2(NUM_TERMS+1).

## Timing
- Reset (async assert, sync release):
  - State IDLE; in_ready=0, out_valid=0, out_data=0x0000, busy=0, acc=0, cnt=0.
- Throughput: one term per 3 cycles max (WAIT, ALIGN, NORM). in_ready is a registered state decode and drops the cycle after acceptance.
- Latency: out_valid rises 2 cycles after the edge that accepts the last term.
- Output stability: out_data and out_valid stay stable while out_valid&&!out_ready.
- busy timing: rises the cycle after start; falls the cycle after the out handshake.
- Back-to-back neurons: start is accepted in the first IDLE cycle after DONE.
- Reset mid-operation: aborts immediately. The partial sum is discarded and no out_valid is issued.

## Test plan
- NUM_TERMS=4, bias 0x0000, terms 0x3C00×4 -> out_data 0x4400.
- NUM_TERMS=4, bias 0x3C00, terms 0xBC00, 0x0000, 0x4000, 0x3800:
  - Intermediate acc 0x0000 after the first term.
  - out_data 0x4100.
- NUM_TERMS=2, bias 0x6400, terms 0x3800, 0x3C00:
  - 0x3800 is truncated away by alignment, leaving acc 0x6400.
  - out_data 0x6401.
- NUM_TERMS=1, bias 0x0401, term 0x8400 -> underflow, out_data 0x0000.
- Handshake stress:
  - Random in_valid gaps: terms are counted only on handshake.
  - out_ready held low 5 cycles: out_valid/out_data stable, in_ready=0, start ignored.
  - out_valid rises exactly 2 cycles after the last accept.
- Reset mid-run: rst_n low during ALIGN of term 2.
  - All outputs take reset values asynchronously.
  - A subsequent full run of the first scenario yields 0x4400.

Source files
------------

// File: rtl/float16_accumulator.sv
// FP16 accumulator: adds NUM_TERMS streamed terms onto a bias, one term per
// WAIT/ALIGN/NORM pass, with truncating add semantics and no subnormals.
module float16_accumulator #(
   parameter int unsigned NUM_TERMS = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bias,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy
);
   localparam int unsigned CntW  = $clog2(NUM_TERMS + 1);
   localparam int unsigned FracW = 11;

   typedef enum logic [2:0] {IDLE, WAIT, ALIGN, NORM, DONE} stateT;
   stateT state, stateNext;

   logic [15:0]      acc, accNext, xReg, xNext, sum;
   logic [CntW-1:0]  cnt, cntNext;
   logic             xZero, accZero, cancelOut, signA, signX;
   logic [4:0]       expL;
   logic [FracW-1:0] fracA, fracX;

   logic             alXZero, alAccZero, alCancel;
   logic [4:0]       alExpL, expDiff;
   logic [FracW-1:0] alFracA, alFracX;

   logic [11:0]      rawSum, diffF;
   logic [FracW-1:0] raw, posF, negF;
   logic             sign;
   logic [5:0]       expW;
   logic [3:0]       shAmt;

   // Align stage: special cases, larger exponent, fractions aligned to it
   always_comb begin
      alXZero   = (xReg == 16'h0000);
      alAccZero = (acc == 16'h0000);
      alCancel  = (acc[14:0] == xReg[14:0]) && (acc[15] != xReg[15]);
      alFracA   = {1'b1, acc[9:0]};
      alFracX   = {1'b1, xReg[9:0]};
      if (acc[14:10] >= xReg[14:10]) begin
         alExpL  = acc[14:10];
         expDiff = acc[14:10] - xReg[14:10];
         alFracX = (expDiff >= 5'd11) ? '0 : (alFracX >> expDiff);
      end else begin
         alExpL  = xReg[14:10];
         expDiff = xReg[14:10] - acc[14:10];
         alFracA = (expDiff >= 5'd11) ? '0 : (alFracA >> expDiff);
      end
   end

   // Normalise stage: add/subtract magnitudes, renormalise, pack
   always_comb begin
      rawSum = '0;
      diffF  = '0;
      posF   = '0;
      negF   = '0;
      raw    = '0;
      sign   = 1'b0;
      shAmt  = '0;
      expW   = 6'({1'b0, expL});
      if (signA == signX) begin
         rawSum = 12'(fracA) + 12'(fracX);
         sign   = signA;
         if (rawSum[11]) begin
            raw  = rawSum[11:1];
            expW = expW + 6'd1;
         end else begin
            raw = rawSum[10:0];
         end
      end else begin
         posF  = signA ? fracX : fracA;
         negF  = signA ? fracA : fracX;
         diffF = 12'(posF) - 12'(negF);
         if (diffF[11]) begin
            sign = 1'b1;
            raw  = 11'(-diffF);
         end else begin
            raw = diffF[10:0];
         end
      end
      if (!raw[10]) begin
         for (int i = 0; i < 11; i++) begin
            if (raw[i]) shAmt = 4'(10 - i);
         end
         raw  = raw << shAmt;
         expW = expW - 6'(shAmt);
      end
      if (xZero)          sum = acc;
      else if (accZero)   sum = xReg;
      else if (cancelOut) sum = 16'h0000;
      else if (expW[5])   sum = 16'h0000;
      else                sum = {sign, expW[4:0], raw[9:0]};
   end

   always_comb begin
      stateNext = state;
      accNext   = acc;
      cntNext   = cnt;
      xNext     = xReg;
      case (state)
         IDLE: if (start) begin
            accNext   = bias;
            cntNext   = '0;
            stateNext = WAIT;
         end
         WAIT: if (in_valid && in_ready) begin
            xNext     = in_data;
            stateNext = ALIGN;
         end
         ALIGN: stateNext = NORM;
         NORM: begin
            accNext   = sum;
            cntNext   = cnt + CntW'(1);
            stateNext = (cnt == CntW'(NUM_TERMS - 1)) ? DONE : WAIT;
         end
         DONE: if (out_valid && out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         xReg      <= '0;
         xZero     <= 1'b0;
         accZero   <= 1'b0;
         cancelOut <= 1'b0;
         signA     <= 1'b0;
         signX     <= 1'b0;
         expL      <= '0;
         fracA     <= '0;
         fracX     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         state <= stateNext;
         acc   <= accNext;
         cnt   <= cntNext;
         xReg  <= xNext;
         if (state == ALIGN) begin
            xZero     <= alXZero;
            accZero   <= alAccZero;
            cancelOut <= alCancel;
            signA     <= acc[15];
            signX     <= xReg[15];
            expL      <= alExpL;
            fracA     <= alFracA;
            fracX     <= alFracX;
         end
         in_ready  <= (stateNext == WAIT);
         out_valid <= (stateNext == DONE);
         busy      <= (stateNext != IDLE);
         if (state == NORM && stateNext == DONE) out_data <= accNext;
      end
   end
endmodule
